mac_rx_packet_fifo: RTL and testbench
=====================================

MAC_RX_PACKET_FIFO -- requirements
Module: mac_rx_packet_fifo

Interface
REQ-001 SHALL have parameter MAC_WIDTH, default 8: AXIS data width in bits.
REQ-002 SHALL have parameter TKEEP_WIDTH, default MAC_WIDTH/8: tkeep width.
REQ-003 SHALL have parameter NIC_WIDTH, default MAC_WIDTH+TKEEP_WIDTH+1: stored word width.
REQ-004 SHALL have parameter ADDR_WIDTH, default 11: depth = 2^ADDR_WIDTH words, usable capacity 2^ADDR_WIDTH-1.
REQ-005 SHALL have parameter STORE_FORWARD, default 1: 1 = frame-commit mode, 0 = cut-through mode.
REQ-006 SHALL have parameter DROP_BAD, default 1: 1 = discard frames whose tlast beat has tuser=1 (store-forward mode only).
REQ-007 SHALL have ports: clk in 1 (the single clock); reset in 1 (asynchronous, active-high).
REQ-008 SHALL have ports: rx_axis_tdata in MAC_WIDTH; rx_axis_tkeep in TKEEP_WIDTH; rx_axis_tvalid in 1; rx_axis_tlast in 1; rx_axis_tuser in 1 (bad-frame flag); rx_axis_tready out 1.
REQ-009 SHALL have ports: RX_FIFO_pipe_read_data out NIC_WIDTH; RX_FIFO_pipe_read_req in 1; RX_FIFO_pipe_read_ack out 1.
REQ-010 SHALL have status ports: frame_count out ADDR_WIDTH+1 (complete frames held); occupancy out ADDR_WIDTH+1 (committed words held); drop_count out 16 (frames dropped).

Function
REQ-011 Stored word SHALL be {tlast, tdata, tkeep}, MSB first.
REQ-012 Pointers: rd_ptr, wr_ptr (speculative), commit_ptr; all ADDR_WIDTH bits, increment modulo 2^ADDR_WIDTH.
REQ-013 Full condition: wr_ptr+1 == rd_ptr (mod depth); empty condition: commit_ptr == rd_ptr.
REQ-014 Beat accepted on clk rising edge when tvalid=1 and tready=1.
REQ-015 Store-forward mode: tready SHALL be 1 whenever reset=0 (overflow handled by dropping, never by backpressure).
REQ-016 Store-forward write FSM states: IDLE (no frame open), STORE (frame open, writing), DROP (frame doomed, discarding).
REQ-017 IDLE/STORE, accepted beat, not full: write word at wr_ptr, wr_ptr+1; state STORE (or resolve per REQ-019 if tlast).
REQ-018 IDLE/STORE, accepted beat, full: do not write, wr_ptr <= commit_ptr; state DROP, or IDLE with drop_count+1 if tlast.
REQ-019 Accepted tlast beat written in STORE/IDLE: if DROP_BAD=1 and tuser=1, wr_ptr <= commit_ptr and drop_count+1; else commit_ptr <= wr_ptr+1 and frame_count+1; state IDLE.
REQ-020 DROP: discard all beats; on accepted tlast: drop_count+1, state IDLE.
REQ-021 A frame longer than usable capacity SHALL always be dropped; no partial frame is ever visible on the read side.
REQ-022 Cut-through mode: tready = (reset=0 and not full); every accepted beat written and committed same edge (commit_ptr tracks wr_ptr); tuser ignored; drop_count stays 0; frame_count+1 per accepted tlast beat.
REQ-023 RX_FIFO_pipe_read_ack = (reset=0 and not empty), combinational.
REQ-024 RX_FIFO_pipe_read_data = mem[rd_ptr], combinational; content undefined when ack=0.
REQ-025 On edge with read_req=1 and ack=1: rd_ptr+1; if popped word tlast bit=1, frame_count-1.
REQ-026 Commit and tlast-pop on same edge: frame_count unchanged.
REQ-027 occupancy = commit_ptr - rd_ptr mod 2^ADDR_WIDTH, zero-extended, registered-pointer-derived (combinational).
REQ-028 drop_count saturates at 16'hFFFF.
REQ-029 Simultaneous write and read on the same edge SHALL both succeed; full test uses pre-edge rd_ptr.

Reset
REQ-030 reset=1 SHALL asynchronously clear rd_ptr, wr_ptr, commit_ptr, frame_count, drop_count; FSM to IDLE.
REQ-031 While reset=1: tready=0, read_ack=0, occupancy=0; memory contents not reset.
REQ-032 Reset mid-frame SHALL discard the partial frame; first beat after release starts a new frame.

Verification
REQ-033 Store-forward, 4-beat good frame (tuser=0): read_ack stays 0 until edge after tlast beat, then 1; frame_count=1, occupancy=4; 4 pops give last word tlast bit=1, frame_count=0.
REQ-034 Store-forward, 3-beat frame with tuser=1 on tlast: read_ack never rises; drop_count=1; occupancy=0; next good frame stored from same address.
REQ-035 ADDR_WIDTH=3, no reads, 9-beat frame: tready constantly 1, frame dropped, drop_count=1, occupancy=0; following 7-beat frame commits with occupancy=7.
REQ-036 Cut-through, ADDR_WIDTH=3, no reads: tready falls after 7 accepted beats; one pop re-raises tready next cycle; data order preserved.
REQ-037 Reset asserted during beat 2 of a frame, asynchronously between edges: tready/ack drop immediately, counters 0; post-release 2-beat frame reads back correctly.
REQ-038 Pointer wrap: stream 20 frames of 3 beats with concurrent reads at ADDR_WIDTH=3; all 60 words returned in order, no drops.

Source files
------------

// File: rtl/mac_rx_packet_fifo.sv
// Receive packet FIFO between an AXIS MAC and the NIC read pipe.
// In store-forward mode frames become readable only once complete and good; cut-through commits every beat.
module mac_rx_packet_fifo #(
    parameter int MAC_WIDTH     = 8,
    parameter int TKEEP_WIDTH   = MAC_WIDTH / 8,
    parameter int NIC_WIDTH     = MAC_WIDTH + TKEEP_WIDTH + 1,
    parameter int ADDR_WIDTH    = 11,
    parameter int STORE_FORWARD = 1,
    parameter int DROP_BAD      = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [MAC_WIDTH-1:0]   rx_axis_tdata,
    input  logic [TKEEP_WIDTH-1:0] rx_axis_tkeep,
    input  logic                   rx_axis_tvalid,
    input  logic                   rx_axis_tlast,
    input  logic                   rx_axis_tuser,
    output logic                   rx_axis_tready,
    output logic [NIC_WIDTH-1:0]   RX_FIFO_pipe_read_data,
    input  logic                   RX_FIFO_pipe_read_req,
    output logic                   RX_FIFO_pipe_read_ack,
    output logic [ADDR_WIDTH:0]    frame_count,
    output logic [ADDR_WIDTH:0]    occupancy,
    output logic [15:0]            drop_count
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_STORE, S_DROP} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] commit_ptr_q, commit_ptr_d;
    logic [ADDR_WIDTH:0]   frame_count_q, frame_count_d;
    logic [15:0]           drop_count_q, drop_count_d;
    logic [NIC_WIDTH-1:0]  mem [DEPTH];

    logic                  full, empty, accept, pop, popped_last;
    logic                  wr_en, frame_inc, drop_inc;
    logic [ADDR_WIDTH-1:0] wr_ptr_inc;

    assign wr_ptr_inc  = wr_ptr_q + ADDR_WIDTH'(1);
    assign full        = (wr_ptr_inc == rd_ptr_q);
    assign empty       = (commit_ptr_q == rd_ptr_q);
    assign accept      = rx_axis_tvalid && rx_axis_tready;
    assign pop         = RX_FIFO_pipe_read_req && RX_FIFO_pipe_read_ack;
    assign popped_last = RX_FIFO_pipe_read_data[NIC_WIDTH-1];

    // Store-forward never backpressures: overflow is resolved by dropping the frame.
    assign rx_axis_tready         = (STORE_FORWARD != 0) ? !reset : (!reset && !full);
    assign RX_FIFO_pipe_read_ack  = !reset && !empty;
    assign RX_FIFO_pipe_read_data = mem[rd_ptr_q];
    assign occupancy              = reset ? '0 : {1'b0, commit_ptr_q - rd_ptr_q};
    assign frame_count            = frame_count_q;
    assign drop_count             = drop_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (STORE_FORWARD != 0 && accept) begin
            if (rx_axis_tlast) begin
                state_d = S_IDLE;
            end else if (state_q != S_DROP) begin
                state_d = full ? S_DROP : S_STORE;
            end
        end
    end

    always_comb begin
        wr_en        = 1'b0;
        frame_inc    = 1'b0;
        drop_inc     = 1'b0;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        if (accept) begin
            if (STORE_FORWARD == 0) begin
                wr_en        = 1'b1;
                wr_ptr_d     = wr_ptr_inc;
                commit_ptr_d = wr_ptr_inc;
                frame_inc    = rx_axis_tlast;
            end else if (state_q == S_DROP) begin
                drop_inc = rx_axis_tlast;
            end else if (full) begin
                // Rewind the speculative pointer so the partial frame vanishes.
                wr_ptr_d = commit_ptr_q;
                drop_inc = rx_axis_tlast;
            end else begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_inc;
                if (rx_axis_tlast) begin
                    if (DROP_BAD != 0 && rx_axis_tuser) begin
                        wr_ptr_d = commit_ptr_q;
                        drop_inc = 1'b1;
                    end else begin
                        commit_ptr_d = wr_ptr_inc;
                        frame_inc    = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        rd_ptr_d = pop ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
        // A commit and a tlast pop on the same edge cancel out.
        case ({frame_inc, pop && popped_last})
            2'b10:   frame_count_d = frame_count_q + (ADDR_WIDTH + 1)'(1);
            2'b01:   frame_count_d = frame_count_q - (ADDR_WIDTH + 1)'(1);
            default: frame_count_d = frame_count_q;
        endcase
        drop_count_d = (drop_inc && drop_count_q != 16'hFFFF) ? drop_count_q + 16'd1 : drop_count_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            commit_ptr_q  <= '0;
            frame_count_q <= '0;
            drop_count_q  <= '0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            commit_ptr_q  <= commit_ptr_d;
            frame_count_q <= frame_count_d;
            drop_count_q  <= drop_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= {rx_axis_tlast, rx_axis_tdata, rx_axis_tkeep};
        end
    end

endmodule

// File: tb/tb_mac_rx_packet_fifo.sv
// Directed bench for mac_rx_packet_fifo: one store-forward and one cut-through instance, both 8-word deep.
module tb_mac_rx_packet_fifo;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]  sf_tdata = '0;
    logic        sf_tkeep = 1'b1, sf_tvalid = 1'b0, sf_tlast = 1'b0, sf_tuser = 1'b0, sf_req = 1'b0;
    logic        sf_tready, sf_ack;
    logic [9:0]  sf_rdata;
    logic [3:0]  sf_fc, sf_occ;
    logic [15:0] sf_dc;

    logic [7:0]  ct_tdata = '0;
    logic        ct_tkeep = 1'b1, ct_tvalid = 1'b0, ct_tlast = 1'b0, ct_tuser = 1'b0, ct_req = 1'b0;
    logic        ct_tready, ct_ack;
    logic [9:0]  ct_rdata;
    logic [3:0]  ct_fc, ct_occ;
    logic [15:0] ct_dc;

    int checks = 0;
    int errors = 0;
    int rd_idx = 0;

    mac_rx_packet_fifo #(.MAC_WIDTH(8), .ADDR_WIDTH(3), .STORE_FORWARD(1), .DROP_BAD(1)) u_sf (
        .clk(clk), .reset(reset),
        .rx_axis_tdata(sf_tdata), .rx_axis_tkeep(sf_tkeep), .rx_axis_tvalid(sf_tvalid),
        .rx_axis_tlast(sf_tlast), .rx_axis_tuser(sf_tuser), .rx_axis_tready(sf_tready),
        .RX_FIFO_pipe_read_data(sf_rdata), .RX_FIFO_pipe_read_req(sf_req),
        .RX_FIFO_pipe_read_ack(sf_ack),
        .frame_count(sf_fc), .occupancy(sf_occ), .drop_count(sf_dc)
    );

    mac_rx_packet_fifo #(.MAC_WIDTH(8), .ADDR_WIDTH(3), .STORE_FORWARD(0), .DROP_BAD(1)) u_ct (
        .clk(clk), .reset(reset),
        .rx_axis_tdata(ct_tdata), .rx_axis_tkeep(ct_tkeep), .rx_axis_tvalid(ct_tvalid),
        .rx_axis_tlast(ct_tlast), .rx_axis_tuser(ct_tuser), .rx_axis_tready(ct_tready),
        .RX_FIFO_pipe_read_data(ct_rdata), .RX_FIFO_pipe_read_req(ct_req),
        .RX_FIFO_pipe_read_ack(ct_ack),
        .frame_count(ct_fc), .occupancy(ct_occ), .drop_count(ct_dc)
    );

    function automatic logic [9:0] w(input logic [7:0] d, input logic l);
        return {l, d, 1'b1};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sf_beat(input logic [7:0] d, input logic l, input logic u);
        sf_tdata  = d;
        sf_tlast  = l;
        sf_tuser  = u;
        sf_tvalid = 1'b1;
        tick();
        sf_tvalid = 1'b0;
        sf_tlast  = 1'b0;
        sf_tuser  = 1'b0;
    endtask

    task automatic sf_pop(input string tag, input logic [9:0] exp);
        sf_req = 1'b1;
        chk(tag, {22'd0, sf_rdata}, {22'd0, exp});
        tick();
        sf_req = 1'b0;
    endtask

    task automatic ct_pop(input string tag, input logic [9:0] exp);
        ct_req = 1'b1;
        chk(tag, {22'd0, ct_rdata}, {22'd0, exp});
        tick();
        ct_req = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d;
        // Reset state
        #12;
        chk("rst_sf_tready", sf_tready, 0);
        chk("rst_sf_ack", sf_ack, 0);
        chk("rst_sf_occ", sf_occ, 0);
        chk("rst_ct_tready", ct_tready, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("post_rst_sf_tready", sf_tready, 1);
        chk("post_rst_ct_tready", ct_tready, 1);
        chk("post_rst_sf_fc", sf_fc, 0);
        chk("post_rst_sf_dc", sf_dc, 0);

        // Good 4-beat frame: invisible until tlast commits
        for (int i = 0; i < 4; i++) begin
            d = 8'hA0 + 8'(i);
            sf_beat(d, i == 3, 1'b0);
            if (i < 3) chk("t1_ack_early", sf_ack, 0);
        end
        chk("t1_ack", sf_ack, 1);
        chk("t1_fc", sf_fc, 1);
        chk("t1_occ", sf_occ, 4);
        for (int i = 0; i < 4; i++) begin
            d = 8'hA0 + 8'(i);
            sf_pop("t1_pop", w(d, i == 3));
        end
        chk("t1_fc_after", sf_fc, 0);
        chk("t1_ack_after", sf_ack, 0);

        // Bad frame is discarded, following good frame reuses the space
        for (int i = 0; i < 3; i++) begin
            d = 8'hB0 + 8'(i);
            sf_beat(d, i == 2, i == 2);
            chk("t2_ack_bad", sf_ack, 0);
        end
        chk("t2_dc", sf_dc, 1);
        chk("t2_occ_bad", sf_occ, 0);
        sf_beat(8'hC0, 1'b0, 1'b0);
        sf_beat(8'hC1, 1'b1, 1'b0);
        chk("t2_fc", sf_fc, 1);
        chk("t2_occ", sf_occ, 2);
        sf_pop("t2_pop0", w(8'hC0, 1'b0));
        sf_pop("t2_pop1", w(8'hC1, 1'b1));

        // Oversize frame dropped without backpressure, then a capacity-sized frame fits
        for (int i = 0; i < 9; i++) begin
            chk("t3_tready", sf_tready, 1);
            d = 8'h30 + 8'(i);
            sf_beat(d, i == 8, 1'b0);
        end
        chk("t3_dc", sf_dc, 2);
        chk("t3_occ_drop", sf_occ, 0);
        chk("t3_ack_drop", sf_ack, 0);
        for (int i = 0; i < 7; i++) begin
            d = 8'h40 + 8'(i);
            sf_beat(d, i == 6, 1'b0);
        end
        chk("t3_occ", sf_occ, 7);
        chk("t3_fc", sf_fc, 1);
        for (int i = 0; i < 7; i++) begin
            d = 8'h40 + 8'(i);
            sf_pop("t3_pop", w(d, i == 6));
        end

        // Asynchronous reset during beat 2 of a frame
        sf_beat(8'h50, 1'b1, 1'b0);
        chk("t4_ack_pre", sf_ack, 1);
        sf_beat(8'h60, 1'b0, 1'b0);
        sf_tdata  = 8'h61;
        sf_tvalid = 1'b1;
        #3;
        reset = 1'b1;
        #1;
        chk("t4_tready", sf_tready, 0);
        chk("t4_ack", sf_ack, 0);
        chk("t4_fc", sf_fc, 0);
        chk("t4_dc", sf_dc, 0);
        chk("t4_occ", sf_occ, 0);
        chk("t4_ct_tready", ct_tready, 0);
        sf_tvalid = 1'b0;
        #2;
        reset = 1'b0;
        tick();
        sf_beat(8'h70, 1'b0, 1'b0);
        sf_beat(8'h71, 1'b1, 1'b0);
        chk("t4_fc_new", sf_fc, 1);
        chk("t4_occ_new", sf_occ, 2);
        sf_pop("t4_pop0", w(8'h70, 1'b0));
        sf_pop("t4_pop1", w(8'h71, 1'b1));

        // 20 three-beat frames with concurrent reads, wrapping the pointers
        rd_idx = 0;
        for (int c = 0; c < 70; c++) begin
            if (c < 60) begin
                sf_tdata  = 8'h80 + 8'(c);
                sf_tlast  = (c % 3 == 2);
                sf_tvalid = 1'b1;
            end else begin
                sf_tvalid = 1'b0;
                sf_tlast  = 1'b0;
            end
            sf_req = 1'b1;
            if (sf_ack) begin
                d = 8'h80 + 8'(rd_idx);
                chk("t5_data", {22'd0, sf_rdata}, {22'd0, w(d, rd_idx % 3 == 2)});
                rd_idx++;
            end
            tick();
            if (c < 60 && c % 3 == 2) chk("t5_fc", sf_fc, 1);
        end
        sf_req = 1'b0;
        chk("t5_count", rd_idx, 60);
        chk("t5_fc_end", sf_fc, 0);
        chk("t5_occ_end", sf_occ, 0);
        chk("t5_dc_end", sf_dc, 0);

        // Cut-through: backpressure when full, one pop re-opens the input
        for (int i = 0; i < 7; i++) begin
            chk("t6_tready", ct_tready, 1);
            ct_tdata  = 8'h10 + 8'(i);
            ct_tlast  = (i == 3 || i == 6);
            ct_tvalid = 1'b1;
            tick();
        end
        chk("t6_full", ct_tready, 0);
        chk("t6_ack", ct_ack, 1);
        chk("t6_fc", ct_fc, 2);
        chk("t6_occ", ct_occ, 7);
        ct_tdata = 8'h17;
        ct_tlast = 1'b1;
        ct_tuser = 1'b1;
        ct_pop("t6_pop_first", w(8'h10, 1'b0));
        chk("t6_reraise", ct_tready, 1);
        chk("t6_occ_pop", ct_occ, 6);
        tick();
        ct_tvalid = 1'b0;
        ct_tlast  = 1'b0;
        ct_tuser  = 1'b0;
        chk("t6_full_again", ct_tready, 0);
        chk("t6_fc_user", ct_fc, 3);
        chk("t6_occ_full", ct_occ, 7);
        for (int i = 1; i < 8; i++) begin
            d = 8'h10 + 8'(i);
            ct_pop("t6_pop", w(d, i == 3 || i == 6 || i == 7));
        end
        chk("t6_fc_end", ct_fc, 0);
        chk("t6_dc", ct_dc, 0);
        chk("t6_ack_end", ct_ack, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
